// File: rtl/f_stage_rounds_if.sv
// Handshake and data bundle for the SHA-256 round stage.
// The slave side is the round engine; the master side supplies state, constants and words.
interface f_stage_rounds_if #(
  parameter int UNROLL = 1
);
  logic                    run;
  logic [255:0]            state_in;
  logic [32*UNROLL-1:0]    k_in;
  logic [32*UNROLL-1:0]    w_in;
  logic [6:0]              kw_round;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [255:0]            state_out;

  modport master (
    output run, state_in, k_in, w_in, out_ready,
    input  kw_round, busy, out_valid, state_out
  );

  modport slave (
    input  run, state_in, k_in, w_in, out_ready,
    output kw_round, busy, out_valid, state_out
  );
endinterface

// File: rtl/f_stage_rounds.sv
// SHA-256 compression rounds, UNROLL chained rounds per clock, with an IDLE/RUN/DONE handshake.
// Define F_STAGE_FEEDFWD_EN to add the captured input state to the result (Davies-Meyer).
module f_stage_rounds #(
  parameter int ROUNDS = 64,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  f_stage_rounds_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [255:0] work_q, work_d;
  logic [255:0] state_out_q, state_out_d;
  logic [6:0]   kw_q, kw_d;
  logic [255:0] rounds_out;
  logic [255:0] final_out;
  logic         last_c;
  logic         accept_c;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s,
                                             input logic [31:0]  k,
                                             input logic [31:0]  w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  always_comb begin
    rounds_out = work_q;
    for (int i = 0; i < UNROLL; i++) begin
      rounds_out = sha_round(rounds_out, bus.k_in[32*i +: 32], bus.w_in[32*i +: 32]);
    end
  end

  assign last_c   = (state_q == RUN) && ((kw_q + 7'(UNROLL)) == 7'(ROUNDS));
  // A finished block may hand straight over to the next one when the result is taken.
  assign accept_c = bus.run && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));

`ifdef F_STAGE_FEEDFWD_EN
  logic [255:0] init_q, init_d;

  always_comb begin
    init_d = init_q;
    if (accept_c) init_d = bus.state_in;
    final_out = '0;
    for (int i = 0; i < 8; i++) begin
      final_out[32*i +: 32] = rounds_out[32*i +: 32] + init_q[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) init_q <= '0;
    else      init_q <= init_d;
  end
`else
  assign final_out = rounds_out;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.run) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = bus.run ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.out_valid = (state_q == DONE);
  end

  always_comb begin
    work_d      = work_q;
    kw_d        = kw_q;
    state_out_d = state_out_q;
    if (accept_c) begin
      work_d = bus.state_in;
      kw_d   = '0;
    end else if (state_q == RUN) begin
      work_d = rounds_out;
      kw_d   = last_c ? 7'd0 : kw_q + 7'(UNROLL);
      if (last_c) state_out_d = final_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q      <= '0;
      kw_q        <= '0;
      state_out_q <= '0;
    end else begin
      work_q      <= work_d;
      kw_q        <= kw_d;
      state_out_q <= state_out_d;
    end
  end

  assign bus.kw_round  = kw_q;
  assign bus.state_out = state_out_q;

endmodule
